alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter N, default 8, sets the datapath width of operands and results.
REQ-002 Parameter CNT_W, default 16, sets the width of the transaction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream result pair is valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 unit_sel  input  1  source select: 0 = logic unit, 1 = arithmetic unit.
REQ-008 rl  input  N  logic-unit result, signed.
REQ-009 ra  input  N  arithmetic-unit result, signed.
REQ-010 ca  input  1  arithmetic carry-out.
REQ-011 va  input  1  arithmetic signed overflow.
REQ-012 out_valid  output  1  y and flags hold a valid entry.
REQ-013 out_ready  input  1  downstream accepts the entry this cycle.
REQ-014 y  output  N  selected result, signed.
REQ-015 flags  output  5  {Z, N, C, V, P} for y.
REQ-016 txn_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-017 The input handshake SHALL fire when in_valid && in_ready, capturing the result selected by unit_sel and its flags as one entry.
REQ-018 Flag rules: Z = (result == 0); N = result[N-1]; P = ~^result (1 on even ones count); C = ca and V = va when unit_sel = 1; C = V = 0 when unit_sel = 0.
REQ-019 Entries SHALL be held in a 2-entry FIFO and presented in acceptance order.
REQ-020 Latency: an entry accepted at edge k SHALL be visible on y/flags with out_valid = 1 immediately after edge k when the FIFO was empty.
REQ-021 in_ready SHALL be 1 when occupancy < 2 and SHALL NOT depend combinationally on out_ready.
REQ-022 The output handshake SHALL fire when out_valid && out_ready, removing the head entry.
REQ-023 When occupancy is 1 and both handshakes fire in the same cycle, occupancy SHALL stay 1 and the new entry SHALL become the head.
REQ-024 When occupancy is 2 and out_ready = 1, occupancy SHALL become 1 and in_ready SHALL be 1 in the next cycle.
REQ-025 When out_valid = 0, y and flags SHALL be 0.
REQ-026 While out_valid = 1 and out_ready = 0, y and flags SHALL hold stable.
REQ-027 txn_cnt SHALL increment by 1 on every output handshake and wrap from 2^CNT_W-1 to 0.
REQ-028 The occupancy state machine SHALL have states EMPTY, ONE and FULL with transitions per REQ-020 to REQ-024; no other states are reachable.

Reset
REQ-029 While rst_n = 0: out_valid = 0, y = 0, flags = 0, txn_cnt = 0, occupancy = EMPTY, in_ready = 0.
REQ-030 in_ready SHALL rise at the first rising clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries immediately without completing any handshake.

Structure
REQ-032 A shared package alu_pkg SHALL hold flag bit-index constants (FLG_Z=4, FLG_N=3, FLG_C=2, FLG_V=1, FLG_P=0), the unit_sel encodings (SEL_LOGIC=0, SEL_ARITH=1) and the occupancy state encoding.
REQ-033 Flag computation SHALL live in a single combinational sub-module, alu_flag_gen, parameterized by N.

Verification
REQ-034 unit_sel=0, rl=0x00, out_ready=1 -> y=0x00, flags={Z=1, N=0, C=0, V=0, P=1} one cycle later, txn_cnt=1.
REQ-035 unit_sel=1, ra=0x80, ca=1, va=1 -> y=0x80, flags={Z=0, N=1, C=1, V=1, P=0}.
REQ-036 out_ready=0, push 0x11, 0x22, then offer 0x33 -> in_ready=0 after the second push; raising out_ready delivers 0x11 then 0x22, and 0x33 is accepted only once in_ready returns to 1.
REQ-037 Occupancy ONE holding 0x11, same-cycle push of 0x44 with out_ready=1 -> 0x11 is consumed, y=0x44 next cycle, out_valid stays 1.
REQ-038 rst_n pulsed low with 2 entries stored -> out_valid=0, y=0, in_ready=0 immediately; in_ready=1 after the first edge post-deassertion.
REQ-039 Preload txn_cnt to 0xFFFF via 65535 output handshakes, then one more handshake -> txn_cnt=0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU result stage.
// Flag bit positions, unit select codes, occupancy encoding.
package alu_pkg;

  localparam int FLG_W = 5;
  localparam int FLG_Z = 4;
  localparam int FLG_N = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_P = 0;

  localparam logic SEL_LOGIC = 1'b0;
  localparam logic SEL_ARITH = 1'b1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Result select and {Z,N,C,V,P} flag generation.
// Purely combinational; carry/overflow only from the arith unit.
import alu_pkg::*;

module alu_flag_gen #(
  parameter int N = 8
) (
  input  logic                unit_sel,
  input  logic signed [N-1:0] rl,
  input  logic signed [N-1:0] ra,
  input  logic                ca,
  input  logic                va,
  output logic signed [N-1:0] res,
  output logic [FLG_W-1:0]    flags
);

  // select the source, then derive flags from the chosen value
  always_comb begin
    res   = rl;
    flags = '0;
    unique case (unit_sel)
      SEL_ARITH: begin
        res          = ra;
        flags[FLG_C] = ca;
        flags[FLG_V] = va;
      end
      default: begin
        res = rl;
      end
    endcase
    flags[FLG_Z] = (res == '0);
    flags[FLG_N] = res[N-1];
    flags[FLG_P] = ~^res;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: select, flag, buffer in a 2-entry FIFO.
// Slot0 is always the head; slot1 only used when FULL.
import alu_pkg::*;

module alu_result_stage #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                unit_sel,
  input  logic signed [N-1:0] rl,
  input  logic signed [N-1:0] ra,
  input  logic                ca,
  input  logic                va,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] y,
  output logic [FLG_W-1:0]    flags,
  output logic [CNT_W-1:0]    txn_cnt
);

  localparam int EW = N + FLG_W;

  occ_e state_q;
  occ_e state_d;

  logic [EW-1:0]      slot0_q;
  logic [EW-1:0]      slot1_q;
  logic [EW-1:0]      new_e;
  logic signed [N-1:0] new_res;
  logic [FLG_W-1:0]   new_flg;
  logic [CNT_W-1:0]   cnt_q;
  logic               rdy_q;
  logic               push;
  logic               pop;
  logic               ld0_new;
  logic               ld1_new;
  logic               shift;

  alu_flag_gen #(
    .N(N)
  ) u_flag (
    .unit_sel (unit_sel),
    .rl       (rl),
    .ra       (ra),
    .ca       (ca),
    .va       (va),
    .res      (new_res),
    .flags    (new_flg)
  );

  assign new_e = {new_res, new_flg};

  // in_ready comes only from registered state, never out_ready
  assign in_ready  = rdy_q && (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign y       = out_valid ? slot0_q[EW-1:FLG_W] : '0;
  assign flags   = out_valid ? slot0_q[FLG_W-1:0] : '0;
  assign txn_cnt = cnt_q;

  // occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // next occupancy and slot load controls
  always_comb begin
    state_d = state_q;
    ld0_new = 1'b0;
    ld1_new = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          state_d = OCC_ONE;
          ld0_new = 1'b1;
        end
      end
      OCC_ONE: begin
        unique case ({push, pop})
          2'b11: begin
            ld0_new = 1'b1;
          end
          2'b10: begin
            ld1_new = 1'b1;
            state_d = OCC_FULL;
          end
          2'b01: begin
            state_d = OCC_EMPTY;
          end
          default: begin
            state_d = OCC_ONE;
          end
        endcase
      end
      OCC_FULL: begin
        if (pop) begin
          state_d = OCC_ONE;
          shift   = 1'b1;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase
  end

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      if (ld0_new) begin
        slot0_q <= new_e;
      end else if (shift) begin
        slot0_q <= slot1_q;
      end
      if (ld1_new) begin
        slot1_q <= new_e;
      end
    end
  end

  // ready enable: low in reset, high from the first edge after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // completed output handshakes, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_alu_result_stage;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             unit_sel = 1'b0;
  logic [N-1:0]     rl = '0;
  logic [N-1:0]     ra = '0;
  logic             ca = 1'b0;
  logic             va = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [N-1:0]     y;
  logic [4:0]       flags;
  logic [CNT_W-1:0] txn_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [12:0]      sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  alu_result_stage #(
    .N(N),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .unit_sel  (unit_sel),
    .rl        (rl),
    .ra        (ra),
    .ca        (ca),
    .va        (va),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .txn_cnt   (txn_cnt)
  );

  function automatic logic [12:0] model(
    input logic s, input logic [7:0] l,
    input logic [7:0] a, input logic c, input logic v
  );
    logic [7:0] r;
    logic [4:0] f;
    r    = s ? a : l;
    f[4] = (r == 8'h00);
    f[3] = r[7];
    f[2] = s ? c : 1'b0;
    f[1] = s ? v : 1'b0;
    f[0] = ~(r[0] ^ r[1] ^ r[2] ^ r[3] ^ r[4] ^ r[5] ^ r[6] ^ r[7]);
    return {r, f};
  endfunction

  task automatic drive(
    input logic vld, input logic s, input logic [7:0] l,
    input logic [7:0] a, input logic c, input logic v,
    input logic rdy
  );
    in_valid  = vld;
    unit_sel  = s;
    rl        = l;
    ra        = a;
    ca        = c;
    va        = v;
    out_ready = rdy;
  endtask

  task automatic step(
    output logic popped, output logic [12:0] got,
    output logic [12:0] want
  );
    popped = 1'b0;
    got    = '0;
    want   = '0;
    if (in_valid && in_ready)
      sb.push_back(model(unit_sel, rl, ra, ca, va));
    if (out_valid && out_ready) begin
      popped = 1'b1;
      got    = {y, flags};
      want   = (sb.size() > 0) ? sb.pop_front() : 13'bx;
      exp_cnt = exp_cnt + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if ({out_valid, y, flags} !== 14'd0)
      $display("FAIL rst_out got %b/%h/%b want 0/00/00000",
               out_valid, y, flags);
    else pass_cnt++;
    total_cnt++;
    if (txn_cnt !== 16'd0)
      $display("FAIL rst_cnt got %h want 0000", txn_cnt);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL rst_rdy got %b want 0", in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL rel_rdy_pre got %b want 0", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL rel_rdy_post got %b want 1", in_ready);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic p;
    logic [12:0] g, w;
    drive(1, 0, 8'h00, 8'h00, 0, 0, 1);
    step(p, g, w);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
    total_cnt++;
    if ({out_valid, y, flags} !== {1'b1, 8'h00, 5'b10001})
      $display("FAIL zero_out got %b/%h/%b want 1/00/10001",
               out_valid, y, flags);
    else pass_cnt++;
    step(p, g, w);
    total_cnt++;
    if ({p, g} !== {1'b1, w})
      $display("FAIL zero_sb got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
    total_cnt++;
    if (txn_cnt !== 16'd1)
      $display("FAIL zero_cnt got %h want 0001", txn_cnt);
    else pass_cnt++;
  endtask

  task automatic test_arith();
    logic p;
    logic [12:0] g, w;
    drive(1, 1, 8'h00, 8'h80, 1, 1, 1);
    step(p, g, w);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
    total_cnt++;
    if ({out_valid, y, flags} !== {1'b1, 8'h80, 5'b01110})
      $display("FAIL arith_out got %b/%h/%b want 1/80/01110",
               out_valid, y, flags);
    else pass_cnt++;
    step(p, g, w);
    total_cnt++;
    if ({p, g} !== {1'b1, w})
      $display("FAIL arith_sb got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
    total_cnt++;
    if (txn_cnt !== exp_cnt)
      $display("FAIL arith_cnt got %h want %h", txn_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_full();
    logic p;
    logic [12:0] g, w;
    drive(1, 0, 8'h11, 8'h00, 0, 0, 0);
    step(p, g, w);
    drive(1, 0, 8'h22, 8'h00, 0, 0, 0);
    step(p, g, w);
    drive(1, 0, 8'h33, 8'h00, 0, 0, 0);
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL full_rdy got %b want 0", in_ready);
    else pass_cnt++;
    step(p, g, w);
    total_cnt++;
    if ({out_valid, y} !== {1'b1, 8'h11})
      $display("FAIL full_hold got %b/%h want 1/11", out_valid, y);
    else pass_cnt++;
    drive(1, 0, 8'h33, 8'h00, 0, 0, 1);
    step(p, g, w);
    total_cnt++;
    if ({p, g[12:5], g} !== {1'b1, 8'h11, w})
      $display("FAIL full_pop1 got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL full_rdy_back got %b want 1", in_ready);
    else pass_cnt++;
    step(p, g, w);
    total_cnt++;
    if ({p, g[12:5], g} !== {1'b1, 8'h22, w})
      $display("FAIL full_pop2 got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
    total_cnt++;
    if ({out_valid, y} !== {1'b1, 8'h33})
      $display("FAIL full_third got %b/%h want 1/33", out_valid, y);
    else pass_cnt++;
    step(p, g, w);
    total_cnt++;
    if ({p, g} !== {1'b1, w})
      $display("FAIL full_pop3 got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid, y, flags} !== 14'd0)
      $display("FAIL empty_zero got %b/%h/%b want 0/00/00000",
               out_valid, y, flags);
    else pass_cnt++;
    total_cnt++;
    if (txn_cnt !== exp_cnt)
      $display("FAIL full_cnt got %h want %h", txn_cnt, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic p;
    logic [12:0] g, w;
    drive(1, 0, 8'h11, 8'h00, 0, 0, 0);
    step(p, g, w);
    drive(1, 0, 8'h44, 8'h00, 0, 0, 1);
    step(p, g, w);
    total_cnt++;
    if ({p, g[12:5], g} !== {1'b1, 8'h11, w})
      $display("FAIL same_pop got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0);
    total_cnt++;
    if ({out_valid, y, in_ready} !== {1'b1, 8'h44, 1'b1})
      $display("FAIL same_head got %b/%h/%b want 1/44/1",
               out_valid, y, in_ready);
    else pass_cnt++;
    step(p, g, w);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 1);
    step(p, g, w);
    total_cnt++;
    if ({p, g} !== {1'b1, w})
      $display("FAIL same_drain got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic p;
    logic [12:0] g, w;
    drive(1, 1, 8'h00, 8'h5a, 0, 1, 0);
    step(p, g, w);
    drive(1, 1, 8'h00, 8'hc3, 1, 0, 0);
    step(p, g, w);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0);
    total_cnt++;
    if ({in_ready, out_valid, y} !== {1'b0, 1'b1, 8'h5a})
      $display("FAIL mid_full got %b/%b/%h want 0/1/5a",
               in_ready, out_valid, y);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, y, flags, in_ready} !== 15'd0)
      $display("FAIL mid_rst got %b/%h/%b/%b want 0/00/00000/0",
               out_valid, y, flags, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (txn_cnt !== 16'd0)
      $display("FAIL mid_cnt got %h want 0000", txn_cnt);
    else pass_cnt++;
    sb.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL mid_rdy_pre got %b want 0", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL mid_rdy_post got %b/%b want 1/0",
               in_ready, out_valid);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic p;
    logic [12:0] g, w;
    int pops = 0;
    int bad = 0;
    for (int i = 0; i < 90000 && pops < 65535; i++) begin
      drive(($urandom_range(0, 9) != 0), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 9) != 0));
      step(p, g, w);
      if (p) begin
        pops++;
        if (g !== w) bad++;
      end
    end
    total_cnt++;
    if (pops !== 65535)
      $display("FAIL wrap_budget got %0d want 65535", pops);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0)
      $display("FAIL wrap_data got %0d bad want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (txn_cnt !== 16'hffff)
      $display("FAIL wrap_pre got %h want ffff", txn_cnt);
    else pass_cnt++;
    p = 1'b0;
    for (int i = 0; i < 10 && !p; i++) begin
      drive(1, 0, 8'($urandom), 8'h00, 0, 0, 1);
      step(p, g, w);
    end
    total_cnt++;
    if ({p, g} !== {1'b1, w})
      $display("FAIL wrap_last got %b/%h want 1/%h", p, g, w);
    else pass_cnt++;
    total_cnt++;
    if (txn_cnt !== 16'h0000)
      $display("FAIL wrap_post got %h want 0000", txn_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_arith();
    test_full();
    test_same_cycle();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
